quad_gen: RTL and testbench

- Quadrature encoder signal generator: converts step commands (direction, step count, step period) into A/B quadrature waveforms.
- Used as a bench and bring-up stimulus source for the quadrature decoder, and to emulate a wheel encoder when no motor is fitted.
- Tracks the signed position it has emitted and pulses done on command completion.
- Phase is continuous across commands, so direction reversals look physically correct to a decoder.

---
 rtl/quad_gen.sv | 129 ++++++++++++
 tb/tb_quad_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_gen.sv
// Quadrature A/B generator: turns step commands (direction, edge count, edge
// period) into continuous-phase quadrature waveforms and tracks signed position.
module quad_gen #(
    parameter int CNT_W = 16,
    parameter int PER_W = 16,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             quad_enc_a,
    output logic             quad_enc_b,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [PER_W-1:0]   timer_q, timer_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;

    logic               accept;
    logic               step;
    logic [PER_W-1:0]   cmd_per_eff;

    // Gray-code step on S = {B,A}; exactly one bit changes per call.
    function automatic logic [1:0] next_phase(input logic [1:0] s, input logic rev);
        if (rev) begin
            next_phase = {~s[0], s[1]};
        end else begin
            next_phase = {s[0], ~s[1]};
        end
    endfunction

    assign accept      = (state_q == IDLE) && cmd_valid;
    assign step        = (state_q == RUN) && !abort && (timer_q == '0);
    assign cmd_per_eff = (cmd_period == '0) ? PER_W'(1) : cmd_period;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && (cmd_steps != '0)) state_d = RUN;
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (step && (rem_q == CNT_W'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == IDLE);
        busy       = (state_q == RUN);
        done       = done_q;
        position   = pos_q;
        quad_enc_a = phase_q[0];
        quad_enc_b = phase_q[1];
    end

    // Command datapath: latch on accept, then count down the period timer.
    always_comb begin
        phase_d = phase_q;
        pos_d   = pos_q;
        timer_d = timer_q;
        per_d   = per_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (accept) begin
            dir_d   = cmd_dir;
            per_d   = cmd_per_eff;
            rem_d   = cmd_steps;
            timer_d = cmd_per_eff - PER_W'(1);
            done_d  = (cmd_steps == '0);
        end else if (step) begin
            phase_d = next_phase(phase_q, dir_q);
            pos_d   = dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
            rem_d   = rem_q - CNT_W'(1);
            timer_d = per_q - PER_W'(1);
            done_d  = (rem_q == CNT_W'(1));
        end else if ((state_q == RUN) && !abort) begin
            timer_d = timer_q - PER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
            pos_q   <= '0;
            timer_q <= '0;
            per_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pos_q   <= pos_d;
            timer_q <= timer_d;
            per_q   <= per_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_quad_gen.sv
// Scoreboard bench for quad_gen: the driver predicts every output edge from the
// command rules, a monitor checks A/B, position, done, busy and ready each cycle.
module tb_quad_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        quad_enc_a, quad_enc_b, busy, done;
    logic [15:0] position;

    quad_gen #(.CNT_W(16), .PER_W(16), .POS_W(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .abort(abort), .quad_enc_a(quad_enc_a), .quad_enc_b(quad_enc_b),
        .busy(busy), .done(done), .position(position)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] pos;
        bit          done;
    } ev_t;

    ev_t         q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          free_cyc = 0;
    int          run_start = 0;
    int          run_end = 0;
    logic [15:0] model_pos = '0;
    logic [15:0] mon_pos = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {B,A} follows position modulo 4 along the cycle 0,1,3,2.
    function automatic logic [1:0] phase_of(input logic [15:0] p);
        case (p[1:0])
            2'd0: phase_of = 2'b00;
            2'd1: phase_of = 2'b01;
            2'd2: phase_of = 2'b11;
            default: phase_of = 2'b10;
        endcase
    endfunction

    ev_t  e;
    bit   exp_done;
    bit   exp_busy;
    logic [1:0] exp_s;

    always @(negedge clk) begin
        if (reset) begin
            exp_done = 1'b0;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("stale_event", 32'(cyc), 32'(e.cyc));
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                mon_pos  = e.pos;
                exp_done = e.done;
            end
            exp_busy = (cyc >= run_start) && (cyc < run_end);
            exp_s    = phase_of(mon_pos);
            chk("enc_a", 32'(quad_enc_a), 32'(exp_s[0]));
            chk("enc_b", 32'(quad_enc_b), 32'(exp_s[1]));
            chk("position", 32'(position), 32'(mon_pos));
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("cmd_ready", 32'(cmd_ready), 32'(!exp_busy));
        end
    end

    task automatic issue(input bit dir, input int steps, input int per,
                         input int abort_j, input bit idle_abort);
        int k, p, n;
        bit aborted;
        while (cyc < free_cyc) begin
            @(posedge clk); #1;
        end
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = steps[15:0];
        cmd_period = per[15:0];
        abort      = idle_abort;
        @(posedge clk); #1;
        k          = cyc;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        cmd_dir    = 1'($urandom);
        cmd_steps  = 16'($urandom);
        cmd_period = 16'($urandom);
        p = (per == 0) ? 1 : per;
        if (steps == 0) begin
            q.push_back('{k, model_pos, 1'b1});
            free_cyc = k;
        end else begin
            aborted = (abort_j > 0) && (abort_j <= p * steps);
            n = aborted ? (abort_j - 1) / p : steps;
            for (int i = 1; i <= n; i++) begin
                model_pos = dir ? model_pos - 16'd1 : model_pos + 16'd1;
                q.push_back('{k + p * i, model_pos, !aborted && (i == steps)});
            end
            run_start = k;
            run_end   = aborted ? k + abort_j : k + p * steps;
            free_cyc  = run_end;
            if (aborted) begin
                while (cyc < k + abort_j - 1) begin
                    @(posedge clk); #1;
                end
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int st, pr, aj;
        bit dr;
        logic [15:0] delta;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", 32'(quad_enc_a), 32'd0);
        chk("rst_b", 32'(quad_enc_b), 32'd0);
        chk("rst_pos", 32'(position), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        free_cyc = cyc;

        issue(1'b0, 8, 3, 0, 1'b0);
        issue(1'b1, 5, 2, 0, 1'b0);
        issue(1'b0, 0, 7, 0, 1'b0);
        issue(1'b0, 3, 0, 0, 1'b1);
        issue(1'b0, 100, 4, 40, 1'b0);

        delta = model_pos - 16'hFFFE;
        issue(1'b1, int'(delta), 1, 0, 1'b0);
        issue(1'b0, 4, 1, 0, 1'b0);

        for (int c = 0; c < 40; c++) begin
            dr = 1'($urandom);
            st = int'($urandom_range(0, 10));
            pr = int'($urandom_range(0, 5));
            aj = 0;
            if (st > 0 && $urandom_range(0, 3) == 0)
                aj = int'($urandom_range(1, ((pr == 0) ? 1 : pr) * st));
            issue(dr, st, pr, aj, 1'($urandom_range(0, 3) == 0));
        end

        issue(1'b0, 20, 4, 0, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        reset     = 1'b0;
        q.delete();
        model_pos = '0;
        mon_pos   = '0;
        run_start = 0;
        run_end   = 0;
        #1;
        chk("mid_rst_a", 32'(quad_enc_a), 32'd0);
        chk("mid_rst_b", 32'(quad_enc_b), 32'd0);
        chk("mid_rst_pos", 32'(position), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        free_cyc = cyc + 4;

        issue(1'b1, 3, 2, 0, 1'b0);
        while (cyc < free_cyc + 3) begin
            @(posedge clk); #1;
        end
        chk("events_left", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
